// File: rtl/idct8x8_core.sv
// idct8x8_core: sequential 8x8 inverse 2-D DCT, one MAC per cycle, clamped 8-bit pixel stream out
module idct8x8_core #(
    parameter int COEF_W = 12,
    parameter int PIX_W  = 8,
    parameter int FRAC   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COEF_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  out_data,
    output logic              busy
);
    typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN, OUTPUT} state_t;
    localparam int PROD_W = COEF_W + 10;
    localparam logic signed [31:0] HALF = 32'sd1 <<< (FRAC - 1);
    localparam logic signed [31:0] OFF = 32'sd1 <<< (PIX_W - 1);
    localparam logic signed [31:0] MAXP = (32'sd1 <<< PIX_W) - 32'sd1;
    localparam longint COS_Q [9] = '{524288, 514214, 484379, 435930, 370728, 291279, 200636, 102284, 0};

    function automatic longint c1d(input int k, input int n);
        int m;
        longint c;
        m = ((2 * n + 1) * k) % 32;
        m = m > 16 ? 32 - m : m;
        c = k == 0 ? 64'sd370728 : COS_Q[m > 8 ? 16 - m : m];
        return m > 8 ? -c : c;
    endfunction

    function automatic logic signed [9:0] basis(input int t, input int p);
        longint prod;
        prod = c1d(t / 8, p / 8) * c1d(t % 8, p % 8);
        return 10'((prod + (64'sd1 <<< (39 - FRAC))) >>> (40 - FRAC));
    endfunction

    state_t state_q, state_d;
    logic signed [COEF_W-1:0] coef_q [64];
    logic [PIX_W-1:0] pix_q [64];
    logic signed [9:0] rom [64][64];
    logic [5:0] idx_q, t_q, p_q, oidx_q, ppix_q;
    logic signed [31:0] acc_q, sum, v, pv;
    logic signed [PROD_W-1:0] prod_q, prod_d;
    logic pv_q, plast_q;
    logic [PIX_W-1:0] pix_d;

    for (genvar i = 0; i < 64; i++) begin : g_t
        for (genvar j = 0; j < 64; j++) begin : g_p
            assign rom[i][j] = basis(i, j);
        end
    end

    // next state and handshake outputs
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    state_d = in_valid && idx_q == 6'd63 ? COMPUTE : LOAD;
            COMPUTE: state_d = t_q == 6'd63 && p_q == 6'd63 ? DRAIN : COMPUTE;
            DRAIN:   state_d = OUTPUT;
            OUTPUT:  state_d = out_ready && oidx_q == 6'd63 ? LOAD : OUTPUT;
            default: state_d = LOAD;
        endcase
        in_ready = state_q == LOAD;
        out_valid = state_q == OUTPUT;
        busy = state_q != LOAD;
        out_data = out_valid ? pix_q[oidx_q] : '0;
    end

    // basis lookup and multiply, then round, offset and clamp of the finished sum
    always_comb begin
        prod_d = coef_q[t_q] * rom[t_q][p_q];
        sum = acc_q + 32'(prod_q);
        v = (sum + HALF) >>> FRAC;
        pv = v + OFF;
        pix_d = pv < 0 ? '0 : pv > MAXP ? {PIX_W{1'b1}} : pv[PIX_W-1:0];
    end

    // control state, indices and the product/accumulate pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            idx_q <= '0;
            t_q <= '0;
            p_q <= '0;
            oidx_q <= '0;
            ppix_q <= '0;
            acc_q <= '0;
            prod_q <= '0;
            pv_q <= 1'b0;
            plast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            prod_q <= prod_d;
            pv_q <= state_q == COMPUTE;
            plast_q <= t_q == 6'd63;
            ppix_q <= p_q;
            if (in_valid && in_ready) idx_q <= idx_q + 6'd1;
            if (state_q == COMPUTE) begin
                t_q <= t_q + 6'd1;
                if (t_q == 6'd63) p_q <= p_q + 6'd1;
            end
            if (pv_q) acc_q <= plast_q ? '0 : sum;
            if (out_valid && out_ready) oidx_q <= oidx_q + 6'd1;
        end
    end

    // coefficient and pixel buffers, never cleared
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) coef_q[idx_q] <= in_data;
        if (pv_q && plast_q) pix_q[ppix_q] <= pix_d;
    end
endmodule

// File: tb/tb_idct8x8_core.sv
// tb_idct8x8_core: directed blocks with hand-derived pixels, latency, backpressure and reset checks
module tb_idct8x8_core;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [11:0] in_data = '0;
    logic in_ready, out_valid, busy;
    logic [7:0] out_data;
    int total = 0, bad = 0;
    int pat [8] = '{139, 137, 134, 130, 126, 122, 119, 117};

    idct8x8_core dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] coef_of(input int mode, input int i);
        case (mode)
            1: return i == 0 ? 12'd80 : 12'd0;
            2: return i == 1 ? 12'd64 : 12'd0;
            3: return i == 0 ? 12'h7FF : 12'd0;
            4: return i == 0 ? 12'h800 : 12'd0;
            5: return i == 0 ? 12'd80 : i == 1 ? 12'd64 : 12'd0;
            default: return 12'd0;
        endcase
    endfunction

    function automatic int exp_of(input int mode, input int n);
        case (mode)
            1: return 138;
            2: return pat[n % 8];
            3: return 255;
            4: return 0;
            5: return pat[n % 8] + 10;
            default: return 128;
        endcase
    endfunction

    task automatic send_block(input int mode, input bit stall);
        int nin = 0;
        for (int i = 0; i < 64; i++) begin
            int w = 0;
            logic rdy;
            if (stall) repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                in_data = 12'h5A5;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data = coef_of(mode, i);
            do begin
                @(negedge clk);
                rdy = in_ready;
                @(posedge clk); #1;
                w++;
            end while (!rdy && w < 20);
            if (rdy) nin++;
        end
        in_valid = 1'b0;
        chk($sformatf("m%0d_in_handshakes", mode), nin, 64);
    endtask

    task automatic run_block(input int mode, input bit stall);
        int lat = 0, n = 0, cyc = 0;
        bit stalled = 1'b0;
        logic [7:0] held = '0;
        send_block(mode, stall);
        if (stall) begin
            in_valid = 1'b1;
            in_data = 12'h3C3;
        end
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                chk($sformatf("m%0d_busy_T1", mode), busy, 1);
                chk($sformatf("m%0d_in_ready_T1", mode), in_ready, 0);
            end
        end while (!out_valid && lat < 5000);
        in_valid = 1'b0;
        chk($sformatf("m%0d_latency", mode), lat, 4098);
        while (n < 64 && cyc < 2000) begin
            @(posedge clk); #1;
            out_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            if (out_valid) begin
                if (stalled) chk($sformatf("m%0d_hold%0d", mode, n), out_data, held);
                if (out_ready) begin
                    chk($sformatf("m%0d_pix%0d", mode, n), out_data, exp_of(mode, n));
                    n++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = out_data;
                end
            end
            cyc++;
        end
        chk($sformatf("m%0d_out_handshakes", mode), n, 64);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk($sformatf("m%0d_in_ready_U1", mode), in_ready, 1);
        chk($sformatf("m%0d_busy_U1", mode), busy, 0);
        chk($sformatf("m%0d_out_valid_U1", mode), out_valid, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        run_block(0, 1'b0);
        run_block(1, 1'b0);
        run_block(2, 1'b0);
        run_block(3, 1'b0);
        run_block(4, 1'b0);
        run_block(5, 1'b1);
        send_block(1, 1'b0);
        repeat (357) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        @(posedge clk); #1;
        run_block(5, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
